// File: rtl/axi4_pkg.sv
// Shared AXI4 types: burst and response encodings, field widths.
// Also holds the WRAP length legality helper used by both FSMs.
package axi4_pkg;

    localparam int LEN_W  = 8;
    localparam int SIZE_W = 3;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_t;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

    function automatic logic wrap_len_ok(input logic [LEN_W-1:0] len);
        return len inside {8'd1, 8'd3, 8'd7, 8'd15};
    endfunction

endpackage

// File: rtl/axi4_burst_addr_gen.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts.
// In: addr, len, size, burst. Out: next_addr (modulo 2^ADDR_WIDTH).
module axi4_burst_addr_gen
    import axi4_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [LEN_W-1:0]      len,
    input  logic [SIZE_W-1:0]     size,
    input  burst_t                burst,
    output logic [ADDR_WIDTH-1:0] next_addr
);

    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] incr;
    logic [ADDR_WIDTH-1:0] wmask;

    always_comb begin
        step  = ADDR_WIDTH'(1) << size;
        // align down first so an unaligned INCR start lands on a boundary
        incr  = (addr & ~(step - ADDR_WIDTH'(1))) + step;
        wmask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size)
              - ADDR_WIDTH'(1);
        unique case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_INCR:  next_addr = incr;
            BURST_WRAP:  next_addr = (addr & ~wmask) | (incr & wmask);
            BURST_RSVD:  next_addr = addr;
        endcase
    end

endmodule

// File: rtl/axi4_sram_slave.sv
// AXI4 slave with on-chip word memory; independent read/write FSMs.
// Ports: clk, rstn, AW/W/B write channels, AR/R read channels.
module axi4_sram_slave
    import axi4_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_DEPTH  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [LEN_W-1:0]        awlen,
    input  logic [SIZE_W-1:0]       awsize,
    input  logic [1:0]              awburst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [LEN_W-1:0]        arlen,
    input  logic [SIZE_W-1:0]       arsize,
    input  logic [1:0]              arburst,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [ID_WIDTH-1:0]     rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready
);

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(NBYTES);
    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] SPAN =
        ADDR_WIDTH'(MEM_DEPTH * NBYTES);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return (a - BASE_ADDR) < SPAN;
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(
        input logic [ADDR_WIDTH-1:0] a
    );
        return IDX_W'((a - BASE_ADDR) >> OFF_W);
    endfunction

    function automatic logic size_bad(
        input logic [SIZE_W-1:0]     s,
        input logic [LEN_W-1:0]      l,
        input logic [1:0]            b,
        input logic [ADDR_WIDTH-1:0] a
    );
        logic [ADDR_WIDTH-1:0] m;
        m = (ADDR_WIDTH'(1) << s) - ADDR_WIDTH'(1);
        return (int'(s) > OFF_W) || (b == BURST_RSVD)
            || (b == BURST_WRAP && (!wrap_len_ok(l) || (a & m) != '0));
    endfunction

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // ---------------- write path ----------------
    wstate_t               w_state, w_next;
    logic [ID_WIDTH-1:0]   w_id;
    logic [ADDR_WIDTH-1:0] w_addr, w_addr_nxt;
    logic [LEN_W-1:0]      w_len, w_cnt;
    logic [SIZE_W-1:0]     w_size;
    burst_t                w_burst;
    logic                  w_err;
    logic                  aw_fire, w_fire, w_last_beat, w_beat_ok;

    assign aw_fire     = awvalid && awready;
    assign w_fire      = wvalid && wready;
    assign w_last_beat = (w_cnt == w_len);
    assign w_beat_ok   = !w_err && in_range(w_addr);
    assign bid         = w_id;
    assign bresp       = w_err ? RESP_SLVERR : RESP_OKAY;

    axi4_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_wgen (
        .addr      (w_addr),
        .len       (w_len),
        .size      (w_size),
        .burst     (w_burst),
        .next_addr (w_addr_nxt)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) w_state <= W_IDLE;
        else       w_state <= w_next;
    end

    always_comb begin
        w_next  = w_state;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                awready = 1'b1;
                if (awvalid) w_next = W_DATA;
            end
            W_DATA: begin
                wready = 1'b1;
                if (wvalid && w_last_beat) w_next = W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_size  <= '0;
            w_burst <= BURST_FIXED;
            w_cnt   <= '0;
            w_err   <= 1'b0;
        end else if (aw_fire) begin
            w_id    <= awid;
            w_addr  <= awaddr;
            w_len   <= awlen;
            w_size  <= awsize;
            w_burst <= burst_t'(awburst);
            w_cnt   <= '0;
            w_err   <= size_bad(awsize, awlen, awburst, awaddr)
                    || !in_range(awaddr);
        end else if (w_fire) begin
            w_addr <= w_addr_nxt;
            w_cnt  <= w_cnt + LEN_W'(1);
            // beat count ends the burst; a wrong wlast only flags it
            if (!w_beat_ok || (wlast != w_last_beat)) w_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_fire && w_beat_ok) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (wstrb[b]) mem[word_idx(w_addr)][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // ---------------- read path ----------------
    rstate_t               r_state, r_next;
    logic [ADDR_WIDTH-1:0] r_addr, r_addr_nxt, rd_addr;
    logic [LEN_W-1:0]      r_len, r_cnt;
    logic [SIZE_W-1:0]     r_size;
    burst_t                r_burst;
    logic                  r_err, rd_err, rd_bad;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  ar_fire, r_fire;

    assign ar_fire = arvalid && arready;
    assign r_fire  = rvalid && rready;

    axi4_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_rgen (
        .addr      (r_addr),
        .len       (r_len),
        .size      (r_size),
        .burst     (r_burst),
        .next_addr (r_addr_nxt)
    );

    // single async read port: start address when idle, else next beat
    always_comb begin
        rd_addr = r_addr_nxt;
        rd_err  = r_err;
        if (r_state == R_IDLE) begin
            rd_addr = araddr;
            rd_err  = size_bad(arsize, arlen, arburst, araddr);
        end
    end

    assign rd_bad  = rd_err || !in_range(rd_addr);
    assign rd_word = mem[word_idx(rd_addr)];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= R_IDLE;
        else       r_state <= r_next;
    end

    always_comb begin
        r_next  = r_state;
        arready = 1'b0;
        rvalid  = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                arready = 1'b1;
                if (arvalid) r_next = R_DATA;
            end
            R_DATA: begin
                rvalid = 1'b1;
                if (rready && rlast) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rid     <= '0;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
            rlast   <= 1'b0;
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= BURST_FIXED;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else if (ar_fire) begin
            rid     <= arid;
            r_addr  <= araddr;
            r_len   <= arlen;
            r_size  <= arsize;
            r_burst <= burst_t'(arburst);
            r_cnt   <= '0;
            r_err   <= rd_err;
            rdata   <= rd_bad ? '0 : rd_word;
            rresp   <= rd_bad ? RESP_SLVERR : RESP_OKAY;
            rlast   <= (arlen == '0);
        end else if (r_fire) begin
            if (rlast) begin
                rlast <= 1'b0;
            end else begin
                r_addr <= r_addr_nxt;
                r_cnt  <= r_cnt + LEN_W'(1);
                rdata  <= rd_bad ? '0 : rd_word;
                rresp  <= rd_bad ? RESP_SLVERR : RESP_OKAY;
                rlast  <= ((r_cnt + LEN_W'(1)) == r_len);
            end
        end
    end

endmodule
